// File: rtl/uart_tx_scheduler_pkg.sv
// Shared definitions for the UART transmit scheduler: FSM state encoding and
// the per-client frame configuration layout.
package uart_tx_scheduler_pkg;

    // Scheduler sequencing states
    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StIssue    = 2'd1,
        StWaitBusy = 2'd2,
        StWaitDone = 2'd3
    } state_e;

    // Packed frame config: {extra_stop, parity_mode[1:0], has_parity, data_bits[1:0]}
    localparam int unsigned CFG_W             = 6;
    localparam int unsigned CFG_DATA_BITS_LSB = 0;
    localparam int unsigned CFG_HAS_PARITY    = 2;
    localparam int unsigned CFG_PARITY_LSB    = 3;
    localparam int unsigned CFG_EXTRA_STOP    = 5;

    typedef struct packed {
        logic       extra_stop;
        logic [1:0] parity_mode;
        logic       has_parity;
        logic [1:0] data_bits;
    } frame_cfg_t;

    // Split a raw client config word into its named fields
    function automatic frame_cfg_t cfg_unpack(input logic [CFG_W-1:0] raw);
        frame_cfg_t c;
        c.data_bits   = raw[CFG_DATA_BITS_LSB +: 2];
        c.has_parity  = raw[CFG_HAS_PARITY];
        c.parity_mode = raw[CFG_PARITY_LSB +: 2];
        c.extra_stop  = raw[CFG_EXTRA_STOP];
        return c;
    endfunction

endpackage

// File: rtl/uart_tx_scheduler_if.sv
// Client-side and transmitter-side signal bundle of the UART transmit scheduler.
// The master modport is the scheduler's view; slave is the clients + transmitter view.
interface uart_tx_scheduler_if #(
    parameter int unsigned NUM_CLIENTS = 4
);
    import uart_tx_scheduler_pkg::*;

    // Client side
    logic [NUM_CLIENTS-1:0]       cl_req;
    logic [NUM_CLIENTS-1:0]       cl_last;
    logic [8*NUM_CLIENTS-1:0]     cl_data;
    logic [CFG_W*NUM_CLIENTS-1:0] cl_cfg;
    logic [NUM_CLIENTS-1:0]       cl_ack;
    logic [NUM_CLIENTS-1:0]       cl_grant;

    // Transmitter side
    logic       tx_ready;
    logic       tx_transmit;
    logic [7:0] tx_data;
    logic [1:0] tx_dataBits;
    logic       tx_hasParity;
    logic [1:0] tx_parityMode;
    logic       tx_extraStopBit;

    modport master (
        input  cl_req,
        input  cl_last,
        input  cl_data,
        input  cl_cfg,
        output cl_ack,
        output cl_grant,
        input  tx_ready,
        output tx_transmit,
        output tx_data,
        output tx_dataBits,
        output tx_hasParity,
        output tx_parityMode,
        output tx_extraStopBit
    );

    modport slave (
        output cl_req,
        output cl_last,
        output cl_data,
        output cl_cfg,
        input  cl_ack,
        input  cl_grant,
        output tx_ready,
        input  tx_transmit,
        input  tx_data,
        input  tx_dataBits,
        input  tx_hasParity,
        input  tx_parityMode,
        input  tx_extraStopBit
    );

endinterface

// File: rtl/uart_tx_scheduler_rr_pick.sv
// Combinational round-robin picker. A locked owner that is still requesting
// keeps the grant; otherwise the first requester after ptr (wrapping) wins.
module uart_tx_scheduler_rr_pick #(
    parameter int unsigned NUM_CLIENTS = 4,
    parameter int unsigned IDX_W       = 2
) (
    input  logic [NUM_CLIENTS-1:0] req,
    input  logic [IDX_W-1:0]       ptr,
    input  logic                   lock,
    input  logic [IDX_W-1:0]       owner,
    output logic [NUM_CLIENTS-1:0] grant,
    output logic [IDX_W-1:0]       grant_idx,
    output logic                   valid
);

    // Scan candidates from ptr+1 and stop at the first requester
    always_comb begin
        logic [IDX_W-1:0] cand;
        grant     = '0;
        grant_idx = '0;
        valid     = 1'b0;
        cand      = '0;
        if (lock && req[owner]) begin
            grant[owner] = 1'b1;
            grant_idx    = owner;
            valid        = 1'b1;
        end else begin
            for (int unsigned k = 1; k <= NUM_CLIENTS; k++) begin
                cand = IDX_W'((32'(ptr) + k) % NUM_CLIENTS);
                if (!valid && req[cand]) begin
                    grant[cand] = 1'b1;
                    grant_idx   = cand;
                    valid       = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one UART transmitter among NUM_CLIENTS byte producers. Round-robin
// arbitration with message locking, registered mux of the winner's byte and
// frame config, transmit/ready handshake sequencing and a sticky timeout flag
// for a transmitter that never leaves ready after a start strobe.
module uart_tx_scheduler
    import uart_tx_scheduler_pkg::*;
#(
    parameter int unsigned NUM_CLIENTS  = 4,
    parameter int unsigned BUSY_TIMEOUT = 1023,
    parameter int unsigned TO_WIDTH     = 10
) (
    input  logic                clk,
    input  logic                rst_n,
    uart_tx_scheduler_if.master bus,
    output logic                busy,
    output logic                err_timeout,
    input  logic                err_clear
);

    localparam int unsigned          IDX_W    = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
    localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(NUM_CLIENTS - 1);
    localparam logic [TO_WIDTH-1:0]  TO_LIMIT = TO_WIDTH'(BUSY_TIMEOUT);

    state_e                 state_q, state_d;
    logic                   lock_q, lock_d;
    logic [IDX_W-1:0]       ptr_q, ptr_d;
    logic [TO_WIDTH-1:0]    cnt_q, cnt_d;
    logic                   err_q, err_d;
    logic                   busy_q, busy_d;
    logic [NUM_CLIENTS-1:0] grant_q, grant_d;
    logic [NUM_CLIENTS-1:0] ack_q, ack_d;
    logic                   transmit_q, transmit_d;
    logic [7:0]             data_q, data_d;
    frame_cfg_t             cfg_q, cfg_d;

    logic [NUM_CLIENTS-1:0] pick_grant;
    logic [IDX_W-1:0]       pick_idx;
    logic                   pick_valid;

    // ptr_q doubles as the lock owner: it always holds the last winner
    uart_tx_scheduler_rr_pick #(
        .NUM_CLIENTS (NUM_CLIENTS),
        .IDX_W       (IDX_W)
    ) u_rr_pick (
        .req       (bus.cl_req),
        .ptr       (ptr_q),
        .lock      (lock_q),
        .owner     (ptr_q),
        .grant     (pick_grant),
        .grant_idx (pick_idx),
        .valid     (pick_valid)
    );

    // Next-state and registered-output decode
    always_comb begin
        state_d    = state_q;
        lock_d     = lock_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        grant_d    = grant_q;
        data_d     = data_q;
        cfg_d      = cfg_q;
        ack_d      = '0;
        transmit_d = 1'b0;

        // A timeout firing below overrides this clear
        if (err_clear) begin
            err_d = 1'b0;
        end

        case (state_q)
            StIdle: begin
                // Owner abandoned its message: release so the full ring competes
                if (lock_q && !bus.cl_req[ptr_q]) begin
                    lock_d = 1'b0;
                end
                if (bus.tx_ready && pick_valid) begin
                    state_d    = StIssue;
                    grant_d    = pick_grant;
                    ptr_d      = pick_idx;
                    lock_d     = ~bus.cl_last[pick_idx];
                    data_d     = bus.cl_data[8*pick_idx +: 8];
                    cfg_d      = cfg_unpack(bus.cl_cfg[CFG_W*pick_idx +: CFG_W]);
                    ack_d      = pick_grant;
                    transmit_d = 1'b1;
                end
            end
            StIssue: begin
                cnt_d   = '0;
                state_d = StWaitBusy;
            end
            StWaitBusy: begin
                if (!bus.tx_ready) begin
                    state_d = StWaitDone;
                end else if (cnt_q == TO_LIMIT) begin
                    // Byte is lost (already acked); no retry strobe
                    err_d   = 1'b1;
                    lock_d  = 1'b0;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + TO_WIDTH'(1);
                end
            end
            StWaitDone: begin
                if (bus.tx_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        busy_d = (state_d != StIdle);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            lock_q     <= 1'b0;
            ptr_q      <= LAST_IDX;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
            grant_q    <= '0;
            ack_q      <= '0;
            transmit_q <= 1'b0;
            data_q     <= '0;
            cfg_q      <= '0;
        end else begin
            state_q    <= state_d;
            lock_q     <= lock_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
            grant_q    <= grant_d;
            ack_q      <= ack_d;
            transmit_q <= transmit_d;
            data_q     <= data_d;
            cfg_q      <= cfg_d;
        end
    end

    assign bus.cl_ack          = ack_q;
    assign bus.cl_grant        = grant_q;
    assign bus.tx_transmit     = transmit_q;
    assign bus.tx_data         = data_q;
    assign bus.tx_dataBits     = cfg_q.data_bits;
    assign bus.tx_hasParity    = cfg_q.has_parity;
    assign bus.tx_parityMode   = cfg_q.parity_mode;
    assign bus.tx_extraStopBit = cfg_q.extra_stop;
    assign busy                = busy_q;
    assign err_timeout         = err_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: per-client byte queues, a transmitter stub and a
// message-level round-robin model that predicts the order of acknowledged bytes.
module tb_uart_tx_scheduler;
    import uart_tx_scheduler_pkg::*;

    localparam int unsigned NC = 4;

    typedef struct {
        logic [7:0] data;
        logic       last;
        logic [5:0] cfg;
    } byte_t;

    typedef struct {
        int unsigned client;
        logic [7:0]  data;
        logic [5:0]  cfg;
    } exp_t;

    logic clk       = 1'b0;
    logic rst_n     = 1'b0;
    logic err_clear = 1'b0;
    logic busy;
    logic err_timeout;

    byte_t       cq [NC][$];
    exp_t        exp_q[$];
    int unsigned ack_log[$];
    int unsigned model_ptr = NC - 1;
    int          n_vec = 0;
    int          n_err = 0;
    bit          stub_en = 1'b1;

    uart_tx_scheduler_if #(.NUM_CLIENTS(NC)) bus ();

    uart_tx_scheduler #(
        .NUM_CLIENTS  (NC),
        .BUSY_TIMEOUT (1023),
        .TO_WIDTH     (10)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .busy        (busy),
        .err_timeout (err_timeout),
        .err_clear   (err_clear)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic push_byte(input int unsigned c, input logic [7:0] d, input logic last,
                             input logic [5:0] cfg);
        byte_t b;
        b.data = d;
        b.last = last;
        b.cfg  = cfg;
        cq[c].push_back(b);
    endtask

    // Message-level arbitration: each turn the first non-empty client after the
    // last winner sends its whole message (or until it runs dry).
    task automatic plan_round();
        byte_t       tmp [NC][$];
        byte_t       b;
        exp_t        e;
        int unsigned w;
        int unsigned c;
        bit          found;
        bit          more;
        for (int i = 0; i < NC; i++) tmp[i] = cq[i];
        more = 1'b1;
        while (more) begin
            found = 1'b0;
            w     = 0;
            for (int k = 1; k <= NC; k++) begin
                c = (model_ptr + k) % NC;
                if (!found && tmp[c].size() > 0) begin
                    found = 1'b1;
                    w     = c;
                end
            end
            if (!found) begin
                more = 1'b0;
            end else begin
                model_ptr = w;
                do begin
                    b        = tmp[w].pop_front();
                    e.client = w;
                    e.data   = b.data;
                    e.cfg    = b.cfg;
                    exp_q.push_back(e);
                end while (!b.last && tmp[w].size() > 0);
            end
        end
    endtask

    task automatic drive_clients();
        logic [NC-1:0]   r;
        logic [NC-1:0]   l;
        logic [8*NC-1:0] d;
        logic [6*NC-1:0] c;
        r = '0;
        l = '0;
        d = '0;
        c = '0;
        for (int i = 0; i < NC; i++) begin
            if (cq[i].size() > 0) begin
                r[i]          = 1'b1;
                l[i]          = cq[i][0].last;
                d[8*i +: 8]   = cq[i][0].data;
                c[6*i +: 6]   = cq[i][0].cfg;
            end
        end
        bus.cl_req  = r;
        bus.cl_last = l;
        bus.cl_data = d;
        bus.cl_cfg  = c;
    endtask

    function automatic bit any_pending();
        bit p = 1'b0;
        for (int i = 0; i < NC; i++) if (cq[i].size() > 0) p = 1'b1;
        return p;
    endfunction

    task automatic wait_round(input string tag, input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || any_pending() || busy || bus.tx_ready !== 1'b1)
               && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_eq({tag, "_left"}, exp_q.size(), 0);
        check_eq({tag, "_idle"}, {31'd0, busy}, 0);
    endtask

    task automatic wait_acks(input int unsigned n, input int budget);
        int k = 0;
        while (ack_log.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        check_eq("ack_arrived", ack_log.size(), n);
    endtask

    // Client driver: advance a queue the cycle after its ack
    initial begin : driver
        logic [NC-1:0] ack_seen;
        bus.cl_req  = '0;
        bus.cl_last = '0;
        bus.cl_data = '0;
        bus.cl_cfg  = '0;
        forever begin
            @(negedge clk);
            ack_seen = bus.cl_ack;
            @(posedge clk);
            #1;
            for (int i = 0; i < NC; i++) begin
                if (ack_seen[i] && cq[i].size() > 0) void'(cq[i].pop_front());
            end
            drive_clients();
        end
    end

    // Transmitter stub: ready drops 1 clk after transmit, returns 40 clk later
    initial begin : tx_stub
        bus.tx_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (bus.tx_transmit === 1'b1 && stub_en) begin
                @(negedge clk);
                bus.tx_ready = 1'b0;
                repeat (40) @(negedge clk);
                bus.tx_ready = 1'b1;
            end
        end
    end

    // Every ack/strobe is compared with the next predicted byte
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && (bus.cl_ack != '0 || bus.tx_transmit)) begin
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_ack", {28'd0, bus.cl_ack}, 0);
                end else begin
                    e = exp_q.pop_front();
                    ack_log.push_back(e.client);
                    check_eq("ack", {28'd0, bus.cl_ack}, 32'd1 << e.client);
                    check_eq("grant", {28'd0, bus.cl_grant}, 32'd1 << e.client);
                    check_eq("tx_transmit", {31'd0, bus.tx_transmit}, 1);
                    check_eq("tx_data", {24'd0, bus.tx_data}, {24'd0, e.data});
                    check_eq("tx_cfg", {26'd0, bus.tx_extraStopBit, bus.tx_parityMode,
                                        bus.tx_hasParity, bus.tx_dataBits}, {26'd0, e.cfg});
                end
            end
        end
    end

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic check_outputs_zero(input string tag);
        check_eq({tag, "_ack"}, {28'd0, bus.cl_ack}, 0);
        check_eq({tag, "_grant"}, {28'd0, bus.cl_grant}, 0);
        check_eq({tag, "_transmit"}, {31'd0, bus.tx_transmit}, 0);
        check_eq({tag, "_data"}, {24'd0, bus.tx_data}, 0);
        check_eq({tag, "_cfg"}, {26'd0, bus.tx_extraStopBit, bus.tx_parityMode,
                                 bus.tx_hasParity, bus.tx_dataBits}, 0);
        check_eq({tag, "_busy"}, {31'd0, busy}, 0);
        check_eq({tag, "_err"}, {31'd0, err_timeout}, 0);
    endtask

    initial begin : main
        int unsigned base;
        int unsigned order1 [5];
        int unsigned order2 [4];
        int unsigned order3 [4];
        int          k;
        int          nmsg;
        int          len;
        int          nbytes;

        // Reset state
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 1: all clients request single-byte messages, client 0 twice
        base = ack_log.size();
        push_byte(0, 8'h10, 1'b1, 6'h00);
        push_byte(0, 8'h14, 1'b1, 6'h01);
        push_byte(1, 8'h11, 1'b1, 6'h02);
        push_byte(2, 8'h12, 1'b1, 6'h03);
        push_byte(3, 8'h13, 1'b1, 6'h04);
        plan_round();
        wait_round("t1", 600);
        order1 = '{0, 1, 2, 3, 0};
        for (int i = 0; i < 5; i++) check_eq("t1_order", ack_log[base + i], order1[i]);

        // 2: client 1 three-byte message blocks client 2
        base = ack_log.size();
        push_byte(1, 8'hA1, 1'b0, 6'h05);
        push_byte(1, 8'hA2, 1'b0, 6'h06);
        push_byte(1, 8'hA3, 1'b1, 6'h07);
        push_byte(2, 8'hB1, 1'b1, 6'h08);
        plan_round();
        wait_round("t2", 600);
        order2 = '{1, 1, 1, 2};
        for (int i = 0; i < 4; i++) check_eq("t2_order", ack_log[base + i], order2[i]);

        // 3: client 1 drops its request mid-message; lock must release
        base = ack_log.size();
        push_byte(0, 8'hC0, 1'b1, 6'h09);
        push_byte(1, 8'hC1, 1'b0, 6'h0A);
        push_byte(1, 8'hC2, 1'b0, 6'h0B);
        push_byte(2, 8'hC3, 1'b1, 6'h0C);
        plan_round();
        wait_round("t3", 600);
        order3 = '{0, 1, 1, 2};
        for (int i = 0; i < 4; i++) check_eq("t3_order", ack_log[base + i], order3[i]);

        // 6: client 3 frame config reaches the transmitter and holds mid-frame
        base = ack_log.size();
        push_byte(3, 8'hA5, 1'b1, 6'b1_10_1_11);
        plan_round();
        wait_acks(base + 1, 100);
        k = 0;
        while (bus.tx_ready !== 1'b0 && k < 20) begin
            @(negedge clk);
            k++;
        end
        repeat (5) @(negedge clk);
        check_eq("t6_extra_stop", {31'd0, bus.tx_extraStopBit}, 1);
        check_eq("t6_parity_mode", {30'd0, bus.tx_parityMode}, 2);
        check_eq("t6_has_parity", {31'd0, bus.tx_hasParity}, 1);
        check_eq("t6_data_bits", {30'd0, bus.tx_dataBits}, 3);
        check_eq("t6_data_held", {24'd0, bus.tx_data}, 32'hA5);
        check_eq("t6_busy", {31'd0, busy}, 1);
        wait_round("t6", 200);

        // Randomized rounds
        for (int r = 0; r < 8; r++) begin
            nbytes = 0;
            for (int c = 0; c < NC; c++) begin
                nmsg = $urandom_range(0, 2);
                for (int m = 0; m < nmsg; m++) begin
                    len = $urandom_range(1, 3);
                    for (int b = 0; b < len; b++) begin
                        push_byte(c, 8'($urandom), (b == len - 1), 6'($urandom));
                        nbytes++;
                    end
                end
            end
            plan_round();
            wait_round("rand", nbytes * 60 + 200);
        end

        // 4: transmitter never leaves ready -> sticky timeout
        stub_en = 1'b0;
        base = ack_log.size();
        push_byte(1, 8'h5A, 1'b1, 6'h15);
        plan_round();
        wait_acks(base + 1, 100);
        repeat (995) @(negedge clk);
        check_eq("t4_err_early", {31'd0, err_timeout}, 0);
        check_eq("t4_busy_waiting", {31'd0, busy}, 1);
        k = 0;
        while (err_timeout !== 1'b1 && k < 120) begin
            @(negedge clk);
            k++;
        end
        check_eq("t4_err_set", {31'd0, err_timeout}, 1);
        check_eq("t4_busy_after", {31'd0, busy}, 0);
        repeat (3) @(negedge clk);
        check_eq("t4_err_sticky", {31'd0, err_timeout}, 1);
        err_clear = 1'b1;
        @(negedge clk);
        err_clear = 1'b0;
        check_eq("t4_err_cleared", {31'd0, err_timeout}, 0);
        stub_en = 1'b1;
        wait_round("t4", 100);

        // 5: reset during the frame, then client 0 wins first again
        base = ack_log.size();
        push_byte(2, 8'h77, 1'b1, 6'h2A);
        plan_round();
        wait_acks(base + 1, 100);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_outputs_zero("t5_reset");
        for (int i = 0; i < NC; i++) cq[i].delete();
        exp_q.delete();
        model_ptr = NC - 1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        base = ack_log.size();
        for (int c = 0; c < NC; c++) push_byte(c, 8'($urandom), 1'b1, 6'($urandom));
        plan_round();
        wait_round("t5", 600);
        check_eq("t5_first_winner", ack_log[base], 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
